hangman_game_fsm: RTL

- Game-state controller directly downstream of the word randomizer.
- On start, snapshots the four 6-bit letter codes (letter1..letter4) into a private word register, since the randomizer output changes every clock.
- Accepts one guessed letter per handshake, reveals matching positions, counts wrong guesses and declares win/loss.
- Outputs drive the hex-display and status-LED logic.

---
 rtl/hangman_pkg.sv | 23 ++
 rtl/hangman_letter_match.sv | 20 ++
 rtl/hangman_game_fsm.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman game controller.
// Letter codes follow the hex-display encoding: A = 6'hA through Z = 6'h23.
package hangman_pkg;

  typedef logic [5:0] letter_t;

  localparam letter_t LETTER_A      = 6'h0A;
  localparam letter_t LETTER_Z      = 6'h23;
  localparam letter_t BLANK_DEFAULT = 6'h3F;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    CHECK = 3'd2,
    WON   = 3'd3,
    LOST  = 3'd4
  } game_state_t;

  function automatic logic is_letter(input letter_t code);
    return (code >= LETTER_A) && (code <= LETTER_Z);
  endfunction

endpackage

// File: rtl/hangman_letter_match.sv
// Compares one guessed letter against all four word positions at once,
// so repeated letters in the word are all found in the same cycle.
module hangman_letter_match
  import hangman_pkg::*;
(
  input  letter_t    word1,
  input  letter_t    word2,
  input  letter_t    word3,
  input  letter_t    word4,
  input  letter_t    guess,
  output logic [3:0] match,
  output logic       any_match
);

  always_comb begin
    match     = {(word4 == guess), (word3 == guess), (word2 == guess), (word1 == guess)};
    any_match = |match;
  end

endmodule

// File: rtl/hangman_game_fsm.sv
// Hangman game-state controller: captures the word, checks guesses, tracks win/loss.
// Optional macro HANGMAN_GUESS_HISTORY_EN ignores repeated guesses with a dup pulse.
module hangman_game_fsm
  import hangman_pkg::*;
#(
  parameter int      MAX_WRONG  = 6,
  parameter letter_t BLANK_CODE = BLANK_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  letter_t    letter1,
  input  letter_t    letter2,
  input  letter_t    letter3,
  input  letter_t    letter4,
  input  letter_t    guess,
  input  logic       guess_valid,
  output logic       ready,
  output letter_t    shown1,
  output letter_t    shown2,
  output letter_t    shown3,
  output letter_t    shown4,
  output logic [3:0] revealed,
  output logic [2:0] wrong_count,
  output logic       hit,
  output logic       miss,
  output logic       dup,
  output logic       won,
  output logic       lost
);

  localparam logic [2:0] MAX_WRONG_C = 3'(MAX_WRONG);

  game_state_t state;
  game_state_t state_next;

  letter_t    word_q [4];
  letter_t    guess_q;
  logic [3:0] revealed_q;
  logic [2:0] wrong_q;
  logic       hit_q;
  logic       miss_q;

  logic [3:0] match;
  logic       any_match;
  logic [3:0] revealed_upd;
  logic [2:0] wrong_upd;
  logic       is_dup;
  logic       start_ok;
  logic       guess_ok;

  hangman_letter_match u_match (
    .word1     (word_q[0]),
    .word2     (word_q[1]),
    .word3     (word_q[2]),
    .word4     (word_q[3]),
    .guess     (guess_q),
    .match     (match),
    .any_match (any_match)
  );

  always_comb begin
    start_ok     = start && ((state == IDLE) || (state == WON) || (state == LOST));
    guess_ok     = guess_valid && (state == PLAY) && is_letter(guess);
    revealed_upd = revealed_q | match;
    if (any_match || (wrong_q == MAX_WRONG_C))
      wrong_upd = wrong_q;
    else
      wrong_upd = wrong_q + 3'd1;
  end

`ifdef HANGMAN_GUESS_HISTORY_EN
  logic [25:0] used_q;
  logic [25:0] guess_onehot;
  logic        dup_q;

  always_comb begin
    guess_onehot = 26'b1 << (guess_q - LETTER_A);
    is_dup       = |(used_q & guess_onehot);
  end

  // The used mask is per game, so it clears on start as well as reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      used_q <= '0;
      dup_q  <= 1'b0;
    end else begin
      dup_q <= (state == CHECK) && is_dup;
      if (start_ok)
        used_q <= '0;
      else if ((state == CHECK) && !is_dup)
        used_q <= used_q | guess_onehot;
    end
  end

  assign dup = dup_q;
`else
  assign is_dup = 1'b0;
  assign dup    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Win/loss is decided on the values CHECK is about to write, not the old ones.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, WON, LOST: if (start) state_next = PLAY;
      PLAY:            if (guess_ok) state_next = CHECK;
      CHECK: begin
        if (is_dup)
          state_next = PLAY;
        else if (revealed_upd == 4'hF)
          state_next = WON;
        else if (wrong_upd == MAX_WRONG_C)
          state_next = LOST;
        else
          state_next = PLAY;
      end
      default:         state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == PLAY);
    won   = (state == WON);
    lost  = (state == LOST);
    if (state == LOST) begin
      shown1 = word_q[0];
      shown2 = word_q[1];
      shown3 = word_q[2];
      shown4 = word_q[3];
    end else begin
      shown1 = revealed_q[0] ? word_q[0] : BLANK_CODE;
      shown2 = revealed_q[1] ? word_q[1] : BLANK_CODE;
      shown3 = revealed_q[2] ? word_q[2] : BLANK_CODE;
      shown4 = revealed_q[3] ? word_q[3] : BLANK_CODE;
    end
  end

  // The randomizer output moves every clock, so the word is snapshotted on start.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_q     <= '{default: '0};
      guess_q    <= '0;
      revealed_q <= '0;
      wrong_q    <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      if (start_ok) begin
        word_q[0]  <= letter1;
        word_q[1]  <= letter2;
        word_q[2]  <= letter3;
        word_q[3]  <= letter4;
        revealed_q <= '0;
        wrong_q    <= '0;
      end
      if (guess_ok)
        guess_q <= guess;
      if ((state == CHECK) && !is_dup) begin
        revealed_q <= revealed_upd;
        wrong_q    <= wrong_upd;
        hit_q      <= any_match;
        miss_q     <= !any_match;
      end
    end
  end

  assign revealed    = revealed_q;
  assign wrong_count = wrong_q;
  assign hit         = hit_q;
  assign miss        = miss_q;

endmodule
